// File: rtl/regfile_sb_pkg.sv
// ============================================================================
// regfile_sb_pkg : shared defaults and constants for the LemonPC register file
// Revision 1.0
// ============================================================================
`default_nettype none

package regfile_sb_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_NREAD      = 2;

  // Index of the hardwired-zero register.
  localparam int X0_IDX = 0;

endpackage

`default_nettype wire

// File: rtl/regfile_sb_scoreboard.sv
// ============================================================================
// regfile_sb_scoreboard : per-register busy bits with claim/release priority
// Revision 1.0
// ============================================================================
`default_nettype none

module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wen,
  input  logic [ADDR_WIDTH-1:0]      waddr,
  input  logic                       iss_valid,
  input  logic [ADDR_WIDTH-1:0]      iss_rd,
  input  logic                       flush,
  output logic [(2**ADDR_WIDTH)-1:0] busy,
  output logic [ADDR_WIDTH:0]        busy_cnt
);

  localparam int NREG = 2**ADDR_WIDTH;

  logic [NREG-1:0]   busy_nxt;
  logic [ADDR_WIDTH:0] cnt_nxt;

  // Flush beats a claim, and a claim beats a same-cycle release of that register.
  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = '0;
    for (int r = 0; r < NREG; r++) begin
      if (r == X0_IDX) begin
        busy_nxt[r] = 1'b0;
      end else if (flush) begin
        busy_nxt[r] = 1'b0;
      end else if (iss_valid && (iss_rd == r[ADDR_WIDTH-1:0])) begin
        busy_nxt[r] = 1'b1;
      end else if (wen && (waddr == r[ADDR_WIDTH-1:0])) begin
        busy_nxt[r] = 1'b0;
      end
      cnt_nxt = cnt_nxt + {{ADDR_WIDTH{1'b0}}, busy_nxt[r]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// regfile_sb : multi-port register file with write bypass and busy scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NREAD      = DEF_NREAD,
  parameter int BYPASS     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
  output logic [NREAD*DATA_WIDTH-1:0] rdata,
  output logic [NREAD-1:0]            rbusy,
  input  logic                        wen,
  input  logic [ADDR_WIDTH-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic                        iss_valid,
  input  logic [ADDR_WIDTH-1:0]       iss_rd,
  input  logic                        flush,
  output logic [ADDR_WIDTH:0]         busy_cnt
);

  localparam int NREG = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(X0_IDX);

  logic [DATA_WIDTH-1:0] rf [NREG];
  logic [NREG-1:0]       busy;
  logic                  wr_ok;

  assign wr_ok = wen && (waddr != ZERO_IDX);

  regfile_sb_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .wen       (wen),
    .waddr     (waddr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .busy      (busy),
    .busy_cnt  (busy_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        rf[r] <= '0;
      end
    end else if (wr_ok) begin
      rf[waddr] <= wdata;
    end
  end

  // A same-cycle writeback both supplies the operand and retires its producer.
  always_comb begin
    logic [ADDR_WIDTH-1:0] ra;
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    for (int i = 0; i < NREAD; i++) begin
      ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (ra == ZERO_IDX) begin
        rdata[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        rbusy[i]                          = 1'b0;
      end else if ((BYPASS != 0) && wr_ok && (waddr == ra)) begin
        rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata;
        rbusy[i]                          = 1'b0;
      end else begin
        rdata[i*DATA_WIDTH +: DATA_WIDTH] = rf[ra];
        rbusy[i]                          = busy[ra];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// tb_regfile_sb : directed checks of regfile_sb with and without bypass
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_regfile_sb;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 2;

  logic            clk;
  logic            rst_n;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata, rdata_nb;
  logic [NR-1:0]    rbusy, rbusy_nb;
  logic            wen;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            flush;
  logic [AW:0]     busy_cnt, busy_cnt_nb;

  int n_cmp;
  int n_bad;

  regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .flush(flush), .busy_cnt(busy_cnt)
  );

  regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .wen(wen), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .flush(flush), .busy_cnt(busy_cnt_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; waddr = '0; wdata = '0;
    iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
    #1;
  endtask

  task automatic claim(input logic [AW-1:0] r);
    iss_valid = 1'b1; iss_rd = r;
    step();
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    raddr = '0;
    idle();
    step();
    rst_n = 1'b1;

    // reset state
    rd(5'd3, 5'd4);
    check("rst_rdata", {32'h0, rdata[31:0] | rdata[DW+:32]}, 64'h0);
    check("rst_rbusy", {62'h0, rbusy}, 64'h0);
    check("rst_cnt", {58'h0, busy_cnt}, 64'h0);

    // x0 writes and claims are ignored
    wen = 1'b1; waddr = 5'd0; wdata = 64'hDEAD;
    iss_valid = 1'b1; iss_rd = 5'd0;
    rd(5'd0, 5'd0);
    check("x0_bypass", rdata[DW-1:0], 64'h0);
    step();
    idle();
    rd(5'd0, 5'd0);
    check("x0_rdata", rdata[DW-1:0], 64'h0);
    check("x0_rbusy", {62'h0, rbusy}, 64'h0);
    check("x0_cnt", {58'h0, busy_cnt}, 64'h0);

    // bypass vs. no bypass
    wen = 1'b1; waddr = 5'd5; wdata = 64'h1111;
    step();
    wdata = 64'h1234;
    rd(5'd5, 5'd0);
    check("byp_rdata", rdata[DW-1:0], 64'h1234);
    check("byp_rbusy", {63'h0, rbusy[0]}, 64'h0);
    check("nobyp_old", rdata_nb[DW-1:0], 64'h1111);
    step();
    idle();
    rd(5'd5, 5'd5);
    check("byp_next", rdata[DW-1:0], 64'h1234);
    check("nobyp_next", rdata_nb[DW-1:0], 64'h1234);
    check("same_port", rdata[DW+:DW], 64'h1234);

    // RAW hazard on x7
    claim(5'd7);
    rd(5'd7, 5'd7);
    check("haz_rbusy1", {63'h0, rbusy[1]}, 64'h1);
    check("haz_rbusy0", {63'h0, rbusy[0]}, 64'h1);
    check("haz_cnt", {58'h0, busy_cnt}, 64'h1);
    wen = 1'b1; waddr = 5'd7; wdata = 64'h7777;
    rd(5'd0, 5'd7);
    check("haz_byp_busy", {63'h0, rbusy[1]}, 64'h0);
    check("haz_byp_data", rdata[DW+:DW], 64'h7777);
    check("haz_nb_busy", {63'h0, rbusy_nb[1]}, 64'h1);
    step();
    idle();
    rd(5'd0, 5'd7);
    check("haz_rel_cnt", {58'h0, busy_cnt}, 64'h0);
    check("haz_rel_busy", {63'h0, rbusy[1]}, 64'h0);
    check("haz_rel_data", rdata[DW+:DW], 64'h7777);

    // claim and release of the same register: claim wins
    claim(5'd3);
    check("col_pre_cnt", {58'h0, busy_cnt}, 64'h1);
    iss_valid = 1'b1; iss_rd = 5'd3;
    wen = 1'b1; waddr = 5'd3; wdata = 64'h3333;
    step();
    idle();
    rd(5'd3, 5'd0);
    check("col_cnt", {58'h0, busy_cnt}, 64'h1);
    check("col_busy", {63'h0, rbusy[0]}, 64'h1);
    check("col_data", rdata[DW-1:0], 64'h3333);

    // claim x4 while releasing x3: net zero
    iss_valid = 1'b1; iss_rd = 5'd4;
    wen = 1'b1; waddr = 5'd3; wdata = 64'h3030;
    step();
    idle();
    rd(5'd3, 5'd4);
    check("swap_cnt", {58'h0, busy_cnt}, 64'h1);
    check("swap_busy", {62'h0, rbusy}, 64'h2);
    wen = 1'b1; waddr = 5'd4; wdata = 64'h4444;
    step();
    idle();
    check("swap_rel_cnt", {58'h0, busy_cnt}, 64'h0);

    // flush releases every claim, the write still lands
    claim(5'd1);
    claim(5'd2);
    claim(5'd9);
    check("fl_pre_cnt", {58'h0, busy_cnt}, 64'h3);
    claim(5'd9);
    check("reclaim_cnt", {58'h0, busy_cnt}, 64'h3);
    flush = 1'b1;
    wen = 1'b1; waddr = 5'd2; wdata = 64'h2222;
    iss_valid = 1'b1; iss_rd = 5'd10;
    step();
    idle();
    rd(5'd2, 5'd10);
    check("fl_cnt", {58'h0, busy_cnt}, 64'h0);
    check("fl_cnt_nb", {58'h0, busy_cnt_nb}, 64'h0);
    check("fl_data", rdata[DW-1:0], 64'h2222);
    check("fl_busy", {62'h0, rbusy}, 64'h0);

    // asynchronous reset mid-cycle, spanning an in-flight write
    claim(5'd6);
    check("ar_pre_cnt", {58'h0, busy_cnt}, 64'h1);
    #2;
    rst_n = 1'b0;
    rd(5'd5, 5'd6);
    check("ar_data", rdata[DW-1:0], 64'h0);
    check("ar_busy", {62'h0, rbusy}, 64'h0);
    check("ar_cnt", {58'h0, busy_cnt}, 64'h0);
    wen = 1'b1; waddr = 5'd5; wdata = 64'h5555;
    step();
    idle();
    rst_n = 1'b1;
    rd(5'd5, 5'd2);
    check("ar_drop_wr", rdata[DW-1:0], 64'h0);
    check("ar_data2", rdata[DW+:DW], 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
